// File: rtl/mem_arbiter.sv
// Two-requester (fetch / LSU) arbiter onto a single memory port, one transaction in flight.
// Optional macro RR_ARB_EN selects round-robin arbitration instead of fixed LSU>IF priority.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_err_o,
    input  logic                lsu_req_i,
    input  logic                lsu_we_i,
    input  logic [DATA_W/8-1:0] lsu_be_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    output logic                lsu_gnt_o,
    output logic                lsu_rvalid_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                lsu_err_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic [1:0]          state_dbg
);

    // Handshake: requesters hold req until their 1-cycle gnt; the bus holds mem_req_o
    // with stable payload until mem_gnt_i, then answers with one mem_rvalid_i pulse.
    localparam int BE_W = DATA_W / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q;

    logic any_req, grant, pick_lsu, timeout, resp_ok, done;

`ifdef RR_ARB_EN
    logic last_owner_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        last_owner_q <= OWN_IF;
        else if (grant) last_owner_q <= pick_lsu;
    end

    // On a collision the requester that did not win last time gets the port.
    assign pick_lsu = lsu_req_i && (!if_req_i || (last_owner_q == OWN_IF));
`else
    assign pick_lsu = lsu_req_i;
`endif

    assign any_req = if_req_i || lsu_req_i;
    assign grant   = (state_q == ST_IDLE) && !rst && any_req;
    assign resp_ok = (state_q == ST_RESP) && mem_rvalid_i;
    assign done    = resp_ok || timeout;

    generate
        if (TIMEOUT_CYC > 0) begin : g_wdog
            localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
            localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
            logic [CNT_W-1:0] cnt_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst)                     cnt_q <= '0;
                else if (state_q == ST_IDLE) cnt_q <= '0;
                else if (cnt_q != CNT_MAX)   cnt_q <= cnt_q + CNT_W'(1);
            end

            // A bus event in the expiry cycle wins; >= covers a grant that landed exactly on it.
            assign timeout = (cnt_q >= CNT_LAST) &&
                             (((state_q == ST_ADDR) && !mem_gnt_i) ||
                              ((state_q == ST_RESP) && !mem_rvalid_i));
        end else begin : g_no_wdog
            assign timeout = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant) state_d = ST_ADDR;
            ST_ADDR: begin
                if (timeout)        state_d = ST_IDLE;
                else if (mem_gnt_i) state_d = ST_RESP;
            end
            ST_RESP: if (done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (grant) begin
            owner_q <= pick_lsu;
            if (pick_lsu) begin
                addr_q  <= lsu_addr_i;
                we_q    <= lsu_we_i;
                be_q    <= lsu_be_i;
                wdata_q <= lsu_wdata_i;
            end else begin
                addr_q  <= if_addr_i;
                we_q    <= 1'b0;
                be_q    <= '1;
                wdata_q <= '0;
            end
        end
    end

    assign if_gnt_o     = grant && !pick_lsu;
    assign lsu_gnt_o    = grant && pick_lsu;
    assign if_rvalid_o  = done && (owner_q == OWN_IF);
    assign lsu_rvalid_o = done && (owner_q == OWN_LSU);
    assign if_err_o     = timeout && (owner_q == OWN_IF);
    assign lsu_err_o    = timeout && (owner_q == OWN_LSU);
    assign if_rdata_o   = (resp_ok && (owner_q == OWN_IF))  ? mem_rdata_i : '0;
    assign lsu_rdata_o  = (resp_ok && (owner_q == OWN_LSU)) ? mem_rdata_i : '0;

    assign mem_req_o   = (state_q == ST_ADDR);
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT_CYC=8); expectations follow RR_ARB_EN when defined.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
`ifdef RR_ARB_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk, rst;
    logic              if_req_i, if_gnt_o, if_rvalid_o, if_err_o;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              lsu_req_i, lsu_we_i, lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
    logic [BE_W-1:0]   lsu_be_i;
    logic [ADDR_W-1:0] lsu_addr_i;
    logic [DATA_W-1:0] lsu_wdata_i, lsu_rdata_o;
    logic              mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [BE_W-1:0]   mem_be_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o, mem_rdata_i;
    logic [1:0]        state_dbg;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_d;
    logic              exp_lsu;
    int                checks = 0;
    int                errors = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
        .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_i = 1'b0; if_addr_i = '0;
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_be_i = '0; lsu_addr_i = '0; lsu_wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    endtask

    task automatic drive_resp(input logic [DATA_W-1:0] d);
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = d;
        exp_q.push_back(d);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        chk("rst_state", state_dbg, 2'd0);
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_if_rvalid", if_rvalid_o, 1'b0);
        chk("rst_lsu_rvalid", lsu_rvalid_o, 1'b0);
        rst = 1'b0;

        // 1: IF read 0x100
        step();
        if_req_i = 1'b1; if_addr_i = 32'h100; #1;
        chk("t1_if_gnt", if_gnt_o, 1'b1);
        chk("t1_lsu_gnt", lsu_gnt_o, 1'b0);
        step();
        if_req_i = 1'b0; mem_gnt_i = 1'b1; #1;
        chk("t1_mem_req", mem_req_o, 1'b1);
        chk("t1_mem_addr", mem_addr_o, 32'h100);
        chk("t1_mem_we", mem_we_o, 1'b0);
        chk("t1_mem_be", mem_be_o, 4'hF);
        step();
        drive_resp(32'hDEADBEEF); #1;
        exp_d = exp_q.pop_front();
        chk("t1_if_rvalid", if_rvalid_o, 1'b1);
        chk("t1_if_rdata", if_rdata_o, exp_d);
        chk("t1_if_err", if_err_o, 1'b0);
        chk("t1_lsu_rvalid", lsu_rvalid_o, 1'b0);
        chk("t1_mem_req_resp", mem_req_o, 1'b0);
        step();
        mem_rvalid_i = 1'b0; #1;
        chk("t1_idle", state_dbg, 2'd0);
        chk("t1_if_rdata_zero", if_rdata_o, 32'h0);

        // 2: LSU store collides with IF fetch; LSU first
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_be_i = 4'h3; lsu_addr_i = 32'h200; lsu_wdata_i = 32'h1234;
        if_req_i = 1'b1; if_addr_i = 32'h300; #1;
        chk("t2_lsu_gnt", lsu_gnt_o, 1'b1);
        chk("t2_if_gnt", if_gnt_o, 1'b0);
        step();
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_be_i = '0; lsu_wdata_i = '0; mem_gnt_i = 1'b1; #1;
        chk("t2_mem_we", mem_we_o, 1'b1);
        chk("t2_mem_be", mem_be_o, 4'h3);
        chk("t2_mem_addr", mem_addr_o, 32'h200);
        chk("t2_mem_wdata", mem_wdata_o, 32'h1234);
        chk("t2_if_gnt_busy", if_gnt_o, 1'b0);
        step();
        drive_resp(32'h0000_0055); #1;
        exp_d = exp_q.pop_front();
        chk("t2_lsu_rvalid", lsu_rvalid_o, 1'b1);
        chk("t2_lsu_rdata", lsu_rdata_o, exp_d);
        chk("t2_if_rvalid", if_rvalid_o, 1'b0);
        step();
        mem_rvalid_i = 1'b0; #1;
        chk("t2_if_gnt_next", if_gnt_o, 1'b1);

        // 3: bus grant withheld 3 cycles; stray rvalid during ADDR ignored
        for (int i = 0; i < 4; i++) begin
            step();
            if_req_i = 1'b0;
            mem_gnt_i = (i == 3);
            mem_rvalid_i = (i == 0);
            #1;
            chk("t3_mem_req", mem_req_o, 1'b1);
            chk("t3_mem_addr", mem_addr_o, 32'h300);
            chk("t3_mem_we", mem_we_o, 1'b0);
            chk("t3_mem_be", mem_be_o, 4'hF);
            chk("t3_mem_wdata", mem_wdata_o, 32'h0);
            chk("t3_if_rvalid_stray", if_rvalid_o, 1'b0);
        end
        step();
        drive_resp(32'hCAFEF00D); #1;
        exp_d = exp_q.pop_front();
        chk("t3_if_rvalid", if_rvalid_o, 1'b1);
        chk("t3_if_rdata", if_rdata_o, exp_d);

        // 4: LSU load with no bus grant times out at cycle 8 after gnt
        step();
        mem_rvalid_i = 1'b0; mem_rdata_i = 32'hFFFF_FFFF;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_be_i = 4'hF; lsu_addr_i = 32'h400;
        if_req_i = 1'b1; if_addr_i = 32'h500; #1;
        chk("t4_lsu_gnt", lsu_gnt_o, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            step();
            lsu_req_i = 1'b0; #1;
            chk("t4_wait_mem_req", mem_req_o, 1'b1);
            chk("t4_wait_lsu_rvalid", lsu_rvalid_o, 1'b0);
        end
        step(); #1;
        chk("t4_lsu_rvalid", lsu_rvalid_o, 1'b1);
        chk("t4_lsu_err", lsu_err_o, 1'b1);
        chk("t4_lsu_rdata", lsu_rdata_o, 32'h0);
        chk("t4_if_rvalid", if_rvalid_o, 1'b0);
        chk("t4_if_err", if_err_o, 1'b0);
        step(); #1;
        chk("t4_if_gnt", if_gnt_o, 1'b1);
        chk("t4_lsu_err_clear", lsu_err_o, 1'b0);
        step();
        if_req_i = 1'b0; mem_gnt_i = 1'b1; #1;
        chk("t4_if_mem_addr", mem_addr_o, 32'h500);
        for (int k = 0; k < 6; k++) begin
            step();
            mem_gnt_i = 1'b0; #1;
            chk("t4_resp_wait", if_rvalid_o, 1'b0);
        end
        // rvalid lands in the expiry cycle and wins over the watchdog
        step();
        drive_resp(32'h0000_0011); #1;
        exp_d = exp_q.pop_front();
        chk("t4_edge_if_rvalid", if_rvalid_o, 1'b1);
        chk("t4_edge_if_err", if_err_o, 1'b0);
        chk("t4_edge_if_rdata", if_rdata_o, exp_d);

        // 5: both requesting continuously
        for (int i = 0; i < 4; i++) begin
            step();
            mem_rvalid_i = 1'b0;
            if_req_i = 1'b1; if_addr_i = 32'h800;
            lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h900; #1;
            exp_lsu = RR ? ((i % 2) == 0) : 1'b1;
            chk("t5_lsu_gnt", lsu_gnt_o, exp_lsu);
            chk("t5_if_gnt", if_gnt_o, !exp_lsu);
            step();
            mem_gnt_i = 1'b1; #1;
            chk("t5_mem_addr", mem_addr_o, exp_lsu ? 32'h900 : 32'h800);
            step();
            drive_resp(32'h7000_0000 + i); #1;
            exp_d = exp_q.pop_front();
            chk("t5_lsu_rvalid", lsu_rvalid_o, exp_lsu);
            chk("t5_if_rvalid", if_rvalid_o, !exp_lsu);
            chk("t5_rdata", exp_lsu ? lsu_rdata_o : if_rdata_o, exp_d);
        end

        // 6: reset during RESP drops the transaction
        step();
        idle_inputs(); #1;
        chk("t6_idle", state_dbg, 2'd0);
        step();
        if_req_i = 1'b1; if_addr_i = 32'h700; #1;
        chk("t6_if_gnt", if_gnt_o, 1'b1);
        step();
        if_req_i = 1'b0; mem_gnt_i = 1'b1; #1;
        step();
        mem_gnt_i = 1'b0; #1;
        chk("t6_in_resp", state_dbg, 2'd2);
        rst = 1'b1; #1;
        chk("t6_rst_state", state_dbg, 2'd0);
        chk("t6_rst_mem_req", mem_req_o, 1'b0);
        chk("t6_rst_mem_addr", mem_addr_o, 32'h0);
        chk("t6_rst_if_rvalid", if_rvalid_o, 1'b0);
        step();
        rst = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0; #1;
        chk("t6_stray_if_rvalid", if_rvalid_o, 1'b0);
        chk("t6_stray_lsu_rvalid", lsu_rvalid_o, 1'b0);
        chk("t6_stray_if_rdata", if_rdata_o, 32'h0);
        chk("t6_stray_state", state_dbg, 2'd0);
        step();
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_be_i = 4'hF; lsu_addr_i = 32'h600; #1;
        chk("t6_lsu_gnt", lsu_gnt_o, 1'b1);
        step();
        lsu_req_i = 1'b0; mem_gnt_i = 1'b1; #1;
        chk("t6_mem_addr", mem_addr_o, 32'h600);
        step();
        drive_resp(32'hABCD1234); #1;
        exp_d = exp_q.pop_front();
        chk("t6_lsu_rvalid", lsu_rvalid_o, 1'b1);
        chk("t6_lsu_rdata", lsu_rdata_o, exp_d);
        chk("t6_lsu_err", lsu_err_o, 1'b0);
        step();
        idle_inputs();

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
